// File: rtl/frame_scheduler.sv
`timescale 1ns/1ps
// frame_scheduler: every p_DIVIDER vblank rising edges, runs start/done with each client in fixed order (optional FRAME_SCHED_TIMEOUT_EN).
// Latency: o_Start[0] is high the cycle after the vblank edge is sampled; each sampled done -> next start one cycle later.
// Backpressure: WAIT holds until i_Done[k]; with FRAME_SCHED_TIMEOUT_EN a silent client is skipped after p_TIMEOUT cycles.
module frame_scheduler #(
    parameter int p_CLIENTS = 4,
    parameter int p_DIVIDER = 1,
    parameter int p_TIMEOUT = 255
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    input  logic                 i_VBlank,
    input  logic                 i_Enable,
    input  logic                 i_ClearErr,
    input  logic [p_CLIENTS-1:0] i_Done,
    output logic [p_CLIENTS-1:0] o_Start,
    output logic                 o_Busy,
    output logic                 o_FrameTick,
    output logic                 o_Overrun,
    output logic                 o_Timeout,
    output logic [15:0]          o_FrameCount
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

    localparam logic [2:0] LAST_K   = 3'(p_CLIENTS - 1);
    localparam logic [7:0] DIV_LAST = 8'(p_DIVIDER - 1);

    state_t               state, state_nxt;
    logic [2:0]           k, k_nxt;
    logic [7:0]           div_cnt, div_cnt_nxt;
    logic                 v_q;
    logic                 vb_edge, count_edge, trigger;
    logic                 done_k, tmo_expired;
    logic [p_CLIENTS-1:0] start_nxt;

    assign vb_edge    = i_VBlank & ~v_q;
    assign count_edge = (state == S_IDLE) & i_Enable & vb_edge;
    assign trigger    = count_edge & (div_cnt == DIV_LAST);

    // Only the current client's done bit matters; the others are ignored.
    always_comb begin
        done_k = 1'b0;
        for (int i = 0; i < p_CLIENTS; i++) begin
            if (k == 3'(i)) done_k = i_Done[i];
        end
    end

`ifdef FRAME_SCHED_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(p_TIMEOUT);

    logic [15:0] tmo_cnt;
    logic        tmo_reach;

    // The pulse fires when the count reaches p_TIMEOUT; the FSM advances on the following cycle.
    assign tmo_reach   = (state == S_WAIT) && !done_k && (tmo_cnt == TMO - 16'd1);
    assign tmo_expired = (state == S_WAIT) && (tmo_cnt == TMO);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            tmo_cnt   <= '0;
            o_Timeout <= 1'b0;
        end else begin
            o_Timeout <= tmo_reach;
            if (state != S_WAIT)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO)
                tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign tmo_expired = 1'b0;
    assign o_Timeout   = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        k_nxt       = k;
        div_cnt_nxt = div_cnt;
        start_nxt   = '0;
        if (count_edge) div_cnt_nxt = trigger ? 8'd0 : div_cnt + 8'd1;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_nxt = S_ISSUE;
                    k_nxt     = 3'd0;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_k || tmo_expired) begin
                    if (k == LAST_K) begin
                        state_nxt = S_FINISH;
                    end else begin
                        k_nxt     = k + 3'd1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        for (int i = 0; i < p_CLIENTS; i++) begin
            start_nxt[i] = (state_nxt == S_ISSUE) && (k_nxt == 3'(i));
        end
    end

    // v_q resets high so a reset released inside vblank does not look like an edge.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state   <= S_IDLE;
            k       <= 3'd0;
            div_cnt <= 8'd0;
            v_q     <= 1'b1;
        end else begin
            state   <= state_nxt;
            k       <= k_nxt;
            div_cnt <= div_cnt_nxt;
            v_q     <= i_VBlank;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Start      <= '0;
            o_Busy       <= 1'b0;
            o_FrameTick  <= 1'b0;
            o_FrameCount <= 16'd0;
            o_Overrun    <= 1'b0;
        end else begin
            o_Start     <= start_nxt;
            o_Busy      <= (state_nxt != S_IDLE);
            o_FrameTick <= (state_nxt == S_FINISH);
            if (state_nxt == S_FINISH) o_FrameCount <= o_FrameCount + 16'd1;
            o_Overrun   <= (~i_VBlank & o_Busy) | (o_Overrun & ~i_ClearErr);
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
`timescale 1ns/1ps
// Bench for frame_scheduler (3 clients, divider 2, timeout 8): directed vblank frames, scoreboard of expected output events.
module tb_frame_scheduler;

    localparam int TMO = 8;

    typedef struct {
        int cyc;
        int start;
        int tick;
        int tmo;
        int cnt;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n, vblank, enable, clear_err;
    logic [2:0]  done, start;
    logic        busy, tick, overrun, tmo;
    logic [15:0] fcount;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;
    int   dly[3];
    int   hold[3];
    int   rise[3];
    ev_t  sb[$];

    frame_scheduler #(
        .p_CLIENTS(3),
        .p_DIVIDER(2),
        .p_TIMEOUT(TMO)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_n      (rst_n),
        .i_VBlank     (vblank),
        .i_Enable     (enable),
        .i_ClearErr   (clear_err),
        .i_Done       (done),
        .o_Start      (start),
        .o_Busy       (busy),
        .o_FrameTick  (tick),
        .o_Overrun    (overrun),
        .o_Timeout    (tmo),
        .o_FrameCount (fcount)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int s, input int t, input int o, input int n);
        ev_t e;
        e.cyc   = c;
        e.start = s;
        e.tick  = t;
        e.tmo   = o;
        e.cnt   = n;
        sb.push_back(e);
    endtask

    // Expected events for a sequence whose vblank edge is sampled at posedge e.
    task automatic push_seq(input int e);
        int         s;
        logic [2:0] oh;
        s = e;
        for (int k = 0; k < 3; k++) begin
            oh    = 3'b000;
            oh[k] = 1'b1;
            push(s, int'(oh), 0, 0, 0);
            if (dly[k] == 0) begin
`ifdef FRAME_SCHED_TIMEOUT_EN
                push(s + TMO + 1, 0, 0, 1, 0);
                s = s + TMO + 2;
`else
                return;
`endif
            end else begin
                s = s + dly[k] + 1;
            end
        end
        exp_count++;
        push(s, 0, 1, 0, exp_count);
    endtask

    task automatic vb_frame(input bit trig, input int hi, input int lo);
        vblank = 1'b1;
        if (trig) push_seq(cyc + 1);
        @(negedge clk);
        chk(trig ? "busy_on_trigger" : "busy_no_trigger", int'(busy), int'(trig));
        repeat (hi - 1) @(negedge clk);
        vblank = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Monitor: every output event is matched against the head of the scoreboard.
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (start != 3'b000 || tick || tmo)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", int'({start, tick, tmo}), 0);
                end else begin
                    e = sb.pop_front();
                    chk("ev_cycle", cyc, e.cyc);
                    chk("ev_start", int'(start), e.start);
                    chk("ev_tick", int'(tick), e.tick);
                    chk("ev_timeout", int'(tmo), e.tmo);
                    if (e.tick != 0) chk("ev_count", int'(fcount), e.cnt);
                end
            end
        end
    end

    // Clients: raise done dly cycles after their start, hold it hold cycles; dly 0 never answers.
    initial begin : responder
        for (int i = 0; i < 3; i++) rise[i] = -100;
        done = 3'b000;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (start[i] && dly[i] != 0) rise[i] = cyc + dly[i];
                done[i] = (cyc >= rise[i]) && (cyc < rise[i] + hold[i]);
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int bad;
        rst_n     = 1'b0;
        vblank    = 1'b1;
        enable    = 1'b1;
        clear_err = 1'b0;
        dly       = '{1, 1, 1};
        hold      = '{1, 1, 1};
        repeat (3) @(negedge clk);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_timeout", int'(tmo), 0);
        chk("rst_count", int'(fcount), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_edge_at_release", int'(busy), 0);
        vblank = 1'b0;
        repeat (5) @(negedge clk);

        // Divider: sequences only on edges 2 and 4.
        vb_frame(0, 20, 5);
        vb_frame(1, 20, 5);
        vb_frame(0, 20, 5);
        vb_frame(1, 20, 5);
        chk("div_count", int'(fcount), 2);

        // Handshake latency with a slow client 1 whose done stays high.
        dly  = '{1, 5, 2};
        hold = '{1, 5, 1};
        vb_frame(0, 20, 5);
        vb_frame(1, 20, 5);

        // Overrun: vblank ends while client 1 is still working.
        dly  = '{1, 12, 1};
        hold = '{1, 1, 1};
        vb_frame(0, 20, 5);
        chk("ovr_before", int'(overrun), 0);
        vb_frame(1, 6, 20);
        chk("ovr_set", int'(overrun), 1);
        vblank    = 1'b1;
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovr_clear", int'(overrun), 0);
        vblank = 1'b0;
        repeat (3) @(negedge clk);
        vb_frame(1, 4, 0);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovr_set_wins", int'(overrun), 1);
        repeat (20) @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        chk("ovr_clear_idle", int'(overrun), 0);

        // Enable dropped mid-sequence; the disabled edge must not be counted.
        dly = '{1, 1, 1};
        vb_frame(0, 20, 5);
        vblank = 1'b1;
        push_seq(cyc + 1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        repeat (18) @(negedge clk);
        vblank = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_drop_count", int'(fcount), 6);
        vb_frame(0, 20, 5);
        enable = 1'b1;
        vb_frame(0, 20, 5);
        vb_frame(1, 20, 5);
        chk("en_restore_count", int'(fcount), 7);

`ifdef FRAME_SCHED_TIMEOUT_EN
        dly = '{0, 1, 1};
        vb_frame(0, 20, 5);
        vb_frame(1, 25, 5);
        chk("tmo_count", int'(fcount), 8);
        dly = '{1, 0, 1};
        vb_frame(0, 20, 5);
        vblank = 1'b1;
        push_seq(cyc + 1);
        repeat (6) @(negedge clk);
        chk("pending_before_reset", sb.size(), 3);
`else
        dly = '{0, 1, 1};
        vb_frame(0, 20, 5);
        vblank = 1'b1;
        push_seq(cyc + 1);
        @(negedge clk);
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!busy || tmo) bad++;
        end
        chk("stuck_bad_cycles", bad, 0);
        chk("pending_before_reset", sb.size(), 0);
`endif

        // Reset while a client is in WAIT.
        rst_n = 1'b0;
        #1;
        chk("rst_mid_start", int'(start), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_tick", int'(tick), 0);
        chk("rst_mid_overrun", int'(overrun), 0);
        chk("rst_mid_timeout", int'(tmo), 0);
        chk("rst_mid_count", int'(fcount), 0);
        sb.delete();
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_busy", int'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
